way_fill_writer: RTL and testbench



---
 rtl/way_fill_writer.sv | 170 +++++++++++++++++
 tb/tb_way_fill_writer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/way_fill_writer.sv
// -----------------------------------------------------------------------------
// way_fill_writer
//
// Purpose:
//   Accepts a line-fill request for one cache way (one-hot select) and one set
//   index, collects the line from the fill bus as BEATS narrow beats, then
//   issues a single one-cycle one-hot write strobe to that way's data array
//   with the assembled line. A request whose way select is not exactly one-hot
//   is consumed and flagged with a one-cycle o_err pulse.
//
// Parameters:
//   LINE_SIZE_BYTES  cache line size in bytes
//   WAYS             associativity (at least 2)
//   BEAT_BYTES       fill beat width in bytes; divides LINE_SIZE_BYTES
//   INDEX_BITS       set index width
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_req_valid/o_req_ready   request handshake (ready only in IDLE)
//   i_req_way, i_req_index    one-hot target way, target set
//   i_fill_valid/o_fill_ready beat handshake (ready only in COLLECT)
//   i_fill_data               beat payload, beat 0 lands in the line LSBs
//   i_abort                   cancels an in-flight fill (COLLECT only)
//   o_way_we                  one-hot write strobe, high for the WRITE cycle
//   o_way_index, o_way_data   registered write index and assembled line
//   o_done                    pulse coincident with o_way_we
//   o_err                     pulse the cycle after a rejected request
// -----------------------------------------------------------------------------
module way_fill_writer #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int WAYS            = 4,
    parameter int BEAT_BYTES      = 8,
    parameter int INDEX_BITS      = 6
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [WAYS-1:0]              i_req_way,
    input  logic [INDEX_BITS-1:0]        i_req_index,
    input  logic                         i_fill_valid,
    output logic                         o_fill_ready,
    input  logic [BEAT_BYTES*8-1:0]      i_fill_data,
    input  logic                         i_abort,
    output logic [WAYS-1:0]              o_way_we,
    output logic [INDEX_BITS-1:0]        o_way_index,
    output logic [LINE_SIZE_BYTES*8-1:0] o_way_data,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int BEATS  = LINE_SIZE_BYTES / BEAT_BYTES;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_W = BEAT_BYTES * 8;
    localparam int LINE_W = LINE_SIZE_BYTES * 8;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        cnt;
    logic [WAYS-1:0]         way_q;
    logic [INDEX_BITS-1:0]   index_q;
    logic [LINE_W-1:0]       line_buf;
    logic [LINE_W-1:0]       line_next;

    logic req_onehot;
    logic req_take;
    logic req_reject;
    logic beat_take;
    logic last_beat;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign req_onehot = (i_req_way != '0) &&
                        ((i_req_way & (i_req_way - WAYS'(1))) == '0);

    assign req_take   = (state == S_IDLE) && i_req_valid && req_onehot;
    assign req_reject = (state == S_IDLE) && i_req_valid && !req_onehot;

    // An abort in the same cycle as a beat discards that beat as well.
    assign beat_take  = (state == S_COLLECT) && i_fill_valid && !i_abort;
    assign last_beat  = (cnt == LAST_BEAT);

    // Line buffer with the current beat merged in at its byte offset.
    always_comb begin
        line_next = line_buf;
        line_next[cnt*BEAT_W +: BEAT_W] = i_fill_data;
    end

    // Next-state and output decode. Outputs depend on registered state only.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        state_next   = state;
        o_req_ready  = 1'b0;
        o_fill_ready = 1'b0;
        o_way_we     = '0;
        o_done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (req_take) begin
                    state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                o_fill_ready = 1'b1;
                if (i_abort) begin
                    state_next = S_IDLE;
                end else if (i_fill_valid && last_beat) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_way_we   = way_q;
                o_done     = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            way_q       <= '0;
            index_q     <= '0;
            o_way_index <= '0;
            o_way_data  <= '0;
            o_err       <= 1'b0;
        end else begin
            state <= state_next;
            o_err <= req_reject;
            if (req_take) begin
                way_q   <= i_req_way;
                index_q <= i_req_index;
                cnt     <= '0;
            end
            if (beat_take) begin
                cnt <= cnt + CNT_W'(1);
                // Output registers only change when a complete line is ready,
                // so they hold the last written line/index at all other times.
                if (last_beat) begin
                    o_way_data  <= line_next;
                    o_way_index <= index_q;
                end
            end
        end
    end

    // NOTE: the line buffer has no reset; every byte is overwritten by a beat
    // before it can reach o_way_data, so clearing it would only cost area.
    always_ff @(posedge i_clk) begin
        if (beat_take) begin
            line_buf <= line_next;
        end
    end

endmodule

// File: tb/tb_way_fill_writer.sv
// -----------------------------------------------------------------------------
// tb_way_fill_writer
//
// Purpose:
//   Self-checking bench for way_fill_writer. Drivers issue requests and beats;
//   every legal, non-aborted fill pushes its expected write (way, index, line
//   assembled from the beats sent, write cycle) into a scoreboard queue, and
//   every rejected request pushes its expected o_err cycle. A monitor on the
//   falling edge pops and compares whenever the DUT strobes o_way_we/o_done or
//   o_err.
// -----------------------------------------------------------------------------
module tb_way_fill_writer;

    localparam int LINE_SIZE_BYTES = 64;
    localparam int WAYS            = 4;
    localparam int BEAT_BYTES      = 8;
    localparam int INDEX_BITS      = 6;
    localparam int BEATS           = LINE_SIZE_BYTES / BEAT_BYTES;
    localparam int BEAT_W          = BEAT_BYTES * 8;
    localparam int LINE_W          = LINE_SIZE_BYTES * 8;
    localparam int HS_LIMIT        = 64;

    typedef struct {
        logic [WAYS-1:0]       way;
        logic [INDEX_BITS-1:0] idx;
        logic [LINE_W-1:0]     data;
        int                    cyc;
    } wr_t;

    logic                   i_clk;
    logic                   i_rst_n;
    logic                   i_req_valid;
    logic                   o_req_ready;
    logic [WAYS-1:0]        i_req_way;
    logic [INDEX_BITS-1:0]  i_req_index;
    logic                   i_fill_valid;
    logic                   o_fill_ready;
    logic [BEAT_W-1:0]      i_fill_data;
    logic                   i_abort;
    logic [WAYS-1:0]        o_way_we;
    logic [INDEX_BITS-1:0]  o_way_index;
    logic [LINE_W-1:0]      o_way_data;
    logic                   o_done;
    logic                   o_err;

    way_fill_writer #(
        .LINE_SIZE_BYTES (LINE_SIZE_BYTES),
        .WAYS            (WAYS),
        .BEAT_BYTES      (BEAT_BYTES),
        .INDEX_BITS      (INDEX_BITS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_way    (i_req_way),
        .i_req_index  (i_req_index),
        .i_fill_valid (i_fill_valid),
        .o_fill_ready (o_fill_ready),
        .i_fill_data  (i_fill_data),
        .i_abort      (i_abort),
        .o_way_we     (o_way_we),
        .o_way_index  (o_way_index),
        .o_way_data   (o_way_data),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];
    int  err_q[$];
    int  writes_seen = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge i_clk) begin
        check("done_matches_we", LINE_W'(o_done), LINE_W'(o_way_we != '0));
        if (o_way_we != '0 || o_done) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_write_we", LINE_W'(o_way_we), '0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_we",    LINE_W'(o_way_we),    LINE_W'(e.way));
                check("write_index", LINE_W'(o_way_index), LINE_W'(e.idx));
                check("write_data",  o_way_data,           e.data);
                check("write_cycle", LINE_W'(cyc),         LINE_W'(e.cyc));
            end
        end
        if (o_err) begin
            if (err_q.size() == 0) begin
                check("unexpected_err", LINE_W'(o_err), '0);
            end else begin
                int ec;
                ec = err_q.pop_front();
                check("err_cycle", LINE_W'(cyc), LINE_W'(ec));
            end
        end
    end

    // Waits for one handshake on the request or fill channel; ready is
    // sampled before the edge the handshake completes on.
    task automatic wait_hs(input bit is_req, output bit ok);
        bit rdy;
        ok = 1'b0;
        for (int t = 0; t < HS_LIMIT; t++) begin
            rdy = is_req ? o_req_ready : o_fill_ready;
            @(posedge i_clk);
            #1;
            if (rdy) begin
                ok = 1'b1;
                return;
            end
        end
        check(is_req ? "req_handshake_timeout" : "beat_handshake_timeout", 0, 1);
    endtask

    // One fill transaction. gap_mode: 0 none, 1 one idle cycle between beats,
    // 2 random idle cycles. abort_beat: beat carrying i_abort (-1 none).
    // cut_beat: stop driving after this beat with no abort (-1 none).
    // abort_in_write: raise i_abort during the WRITE cycle.
    task automatic send_fill(input logic [WAYS-1:0] way,
                             input logic [INDEX_BITS-1:0] idx,
                             input int gap_mode, input int abort_beat,
                             input int cut_beat, input bit abort_with_req,
                             input bit abort_in_write,
                             input bit incrementing_data);
        logic [LINE_W-1:0] line;
        logic [BEAT_W-1:0] beat;
        bit ok;
        wr_t e;
        i_req_valid = 1'b1;
        i_req_way   = way;
        i_req_index = idx;
        i_abort     = abort_with_req;
        wait_hs(1'b1, ok);
        i_req_valid = 1'b0;
        i_abort     = 1'b0;
        if (!ok) return;
        if ($countones(way) != 1) begin
            err_q.push_back(cyc);
            return;
        end
        line = '0;
        for (int b = 0; b < BEATS; b++) begin
            int gaps;
            gaps = (b == 0) ? 0 : (gap_mode == 1) ? 1 :
                   (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gaps) begin
                @(posedge i_clk);
                #1;
            end
            beat = incrementing_data ? BEAT_W'(b) : {$urandom, $urandom};
            line[b*BEAT_W +: BEAT_W] = beat;
            i_fill_valid = 1'b1;
            i_fill_data  = beat;
            i_abort      = (b == abort_beat);
            wait_hs(1'b0, ok);
            i_fill_valid = 1'b0;
            i_abort      = 1'b0;
            if (!ok || b == abort_beat || b == cut_beat) return;
        end
        // Write is visible in the cycle right after the final beat edge.
        e.way  = way;
        e.idx  = idx;
        e.data = line;
        e.cyc  = cyc;
        exp_q.push_back(e);
        if (abort_in_write) begin
            i_abort = 1'b1;
            @(posedge i_clk);
            #1;
            i_abort = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  LINE_W'(o_req_ready),  1);
        check({tag, "_fill_ready"}, LINE_W'(o_fill_ready), 0);
        check({tag, "_we"},         LINE_W'(o_way_we),     0);
        check({tag, "_done"},       LINE_W'(o_done),       0);
        check({tag, "_err"},        LINE_W'(o_err),        0);
        check({tag, "_index"},      LINE_W'(o_way_index),  0);
        check({tag, "_data"},       o_way_data,            0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        i_rst_n      = 1'b0;
        i_req_valid  = 1'b0;
        i_req_way    = '0;
        i_req_index  = '0;
        i_fill_valid = 1'b0;
        i_fill_data  = '0;
        i_abort      = 1'b0;
        idle(3);
        check_reset_outputs("reset");
        i_rst_n = 1'b1;
        idle(2);

        // Back-to-back beats, then the same fill with alternating valid.
        send_fill(4'b0100, 6'h15, 0, -1, -1, 1'b0, 1'b0, 1'b1);
        send_fill(4'b0100, 6'h15, 1, -1, -1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Illegal way selects: consumed, flagged, nothing written.
        send_fill(4'b0000, 6'h01, 0, -1, -1, 1'b0, 1'b0, 1'b0);
        send_fill(4'b0110, 6'h02, 0, -1, -1, 1'b0, 1'b0, 1'b0);
        idle(2);
        check("req_ready_after_err", LINE_W'(o_req_ready), 1);

        // Abort with the final beat, then a normal fill to way 0.
        send_fill(4'b1000, 6'h3f, 0, BEATS - 1, -1, 1'b0, 1'b0, 1'b0);
        send_fill(4'b0001, 6'h2a, 0, -1, -1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Abort is ignored in IDLE (with the request) and in WRITE.
        send_fill(4'b0010, 6'h07, 0, -1, -1, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Reset mid-fill after beat 3, then a full fill.
        send_fill(4'b0010, 6'h11, 0, -1, 3, 1'b0, 1'b0, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midfill_reset");
        idle(2);
        i_rst_n = 1'b1;
        idle(1);
        send_fill(4'b1000, 6'h0c, 2, -1, -1, 1'b0, 1'b0, 1'b0);

        // Randomized back-to-back traffic.
        for (int n = 0; n < 60; n++) begin
            logic [WAYS-1:0] w;
            int ab;
            w  = ($urandom_range(0, 5) == 0) ? WAYS'($urandom)
                                             : WAYS'(1) << $urandom_range(0, WAYS - 1);
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            send_fill(w, INDEX_BITS'($urandom), int'($urandom_range(0, 2)), ab, -1,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

        idle(5);
        check("writes_outstanding", LINE_W'(exp_q.size()), 0);
        check("errs_outstanding",   LINE_W'(err_q.size()), 0);
        check("some_writes_seen",   LINE_W'(writes_seen > 10), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
